ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, CLK cycles PS2_CLK is held low before the request (100 us at 50 MHz).
REQ-002 SHALL have parameter REQ_CYCLES, default 16, CLK cycles both lines are held low before PS2_CLK is released.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 750000, watchdog limit in CLK cycles (15 ms at 50 MHz).
REQ-004 SHALL have port CLK  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port START  input  1  one-cycle request to transmit TX_DATA.
REQ-007 SHALL have port TX_DATA  input  8  command byte, e.g. 8'hED set LEDs, 8'hFF reset.
REQ-008 SHALL have port PS2_CLK_IN  input  1  sensed keyboard clock line.
REQ-009 SHALL have port PS2_DATA_IN  input  1  sensed keyboard data line.
REQ-010 SHALL have port PS2_CLK_OE  output  1  1 = drive clock line low, 0 = release.
REQ-011 SHALL have port PS2_DATA_OE  output  1  1 = drive data line low, 0 = release.
REQ-012 SHALL have port BUSY  output  1  high from the cycle after an accepted START until DONE or ERR.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse: byte sent and ACK received.
REQ-014 SHALL have port ERR  output  1  one-cycle pulse: no ACK, or timeout.

Function
REQ-015 SHALL pass PS2_CLK_IN and PS2_DATA_IN through 2-flop synchronizers; falling edge = synced clock was 1 last cycle, 0 now.
REQ-016 SHALL implement states IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE.
REQ-017 In IDLE with START=1, SHALL latch TX_DATA and odd parity (~^TX_DATA) into a 10-bit frame {stop=1, parity, data[7:0]}, set BUSY and enter INHIBIT on the next edge.
REQ-018 SHALL ignore START while BUSY=1; TX_DATA changes after acceptance SHALL NOT affect the frame.
REQ-019 INHIBIT: PS2_CLK_OE=1, PS2_DATA_OE=0 for exactly INHIBIT_CYCLES cycles, then enter REQUEST.
REQ-020 REQUEST: PS2_CLK_OE=1, PS2_DATA_OE=1 (start bit 0) for REQ_CYCLES cycles, then PS2_CLK_OE=0 and enter SEND with bit index 0.
REQ-021 SEND: on each device clock falling edge, set PS2_DATA_OE = ~frame[index] and increment index; edges 1-8 carry data LSB first, edge 9 parity, edge 10 stop (line released); then enter ACK.
REQ-022 ACK: on the next falling edge, sample synced data: 0 enters WAIT_IDLE; 1 pulses ERR, clears BUSY and enters IDLE.
REQ-023 WAIT_IDLE: when synced clock and data are both 1, pulse DONE, clear BUSY and enter IDLE.
REQ-024 PS2_CLK_OE SHALL be 0 in every state except INHIBIT and REQUEST; PS2_DATA_OE SHALL be 0 in IDLE, INHIBIT, ACK and WAIT_IDLE.
REQ-025 DONE and ERR SHALL never be asserted in the same cycle; neither SHALL assert outside a transfer.
REQ-026 A START in the cycle DONE or ERR pulses SHALL be ignored; START is accepted from the following cycle.

Reset
REQ-027 RST=1 SHALL immediately (asynchronously) force IDLE, PS2_CLK_OE=0, PS2_DATA_OE=0, BUSY=0, DONE=0, ERR=0, and clear counters, index and synchronizers to 1.
REQ-028 RST mid-transfer SHALL abandon the frame without pulsing DONE or ERR; lines are released in the same cycle.

Configuration
REQ-029 With PS2_TX_WATCHDOG_EN defined, a counter SHALL restart on entry to SEND and on every falling edge; reaching TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE SHALL release both lines, pulse ERR, clear BUSY and enter IDLE.
REQ-030 Without PS2_TX_WATCHDOG_EN, no watchdog logic SHALL exist and the block SHALL wait indefinitely for device edges.

Verification
REQ-031 START with TX_DATA=8'hED, device model clocks 11 edges and ACKs -> line bits after start: 1,0,1,1,0,1,1,1, parity 1, stop 1; one DONE pulse; BUSY low next cycle.
REQ-032 TX_DATA=8'hF4 -> parity bit 0; TX_DATA=8'h00 -> parity bit 1; both end in DONE.
REQ-033 Device leaves data high on the 11th edge -> ERR pulse, no DONE, both OE=0.
REQ-034 PS2_TX_WATCHDOG_EN defined, TIMEOUT_CYCLES=1000, device stops after 4 edges -> ERR exactly 1000 cycles after the 4th edge; BUSY=0.
REQ-035 RST pulsed during edge 5 of SEND -> PS2_CLK_OE=PS2_DATA_OE=BUSY=0 at once, no DONE/ERR; a following 8'hFF transfer completes normally.
REQ-036 Second START while BUSY with a different TX_DATA -> ignored; transmitted frame matches the first byte.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send and then clocks a
// 10-bit frame {stop, odd parity, data[7:0]} out on device clock
// falling edges before checking the device ACK.
// Optional build macro PS2_TX_WATCHDOG_EN adds a device-clock watchdog.

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] TX_DATA,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);

  if (INHIBIT_CYCLES == 0 || REQ_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("ps2_host_tx: cycle-count parameters must be non-zero");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       idx, idx_n;
  logic [9:0]       frame, frame_n;
  logic             dat_q, dat_q_n;

  logic clk_meta, clk_sync, clk_last;
  logic dat_meta, dat_sync;
  logic fall;

`ifdef PS2_TX_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic            wd_expired;
`endif

  // Line synchronizers; idle bus level is 1, so reset to 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_last <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK_IN;
      clk_sync <= clk_meta;
      clk_last <= clk_sync;
      dat_meta <= PS2_DATA_IN;
      dat_sync <= dat_meta;
    end
  end

  assign fall = clk_last & ~clk_sync;

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      frame <= '0;
      dat_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      frame <= frame_n;
      dat_q <= dat_q_n;
    end
  end

`ifdef PS2_TX_WATCHDOG_EN
  // Watchdog counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt_n;
    end
  end
`endif

  assign BUSY = (state != IDLE);

  // Next-state, datapath and line/handshake outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    frame_n     = frame;
    dat_q_n     = dat_q;
    PS2_CLK_OE  = 1'b0;
    PS2_DATA_OE = 1'b0;
    DONE        = 1'b0;
    ERR         = 1'b0;

`ifdef PS2_TX_WATCHDOG_EN
    wd_cnt_n   = '0;
    wd_expired = 1'b0;
    if (state inside {SEND, ACK, WAIT_IDLE}) begin
      if (fall) begin
        wd_cnt_n = '0;
      end else if (wd_cnt != WD_LAST) begin
        wd_cnt_n = wd_cnt + WD_W'(1);
      end else begin
        wd_cnt_n = wd_cnt;
      end
      wd_expired = !fall && (wd_cnt == WD_LAST);
    end
`endif

    case (state)
      IDLE: begin
        if (START) begin
          frame_n = {1'b1, ~^TX_DATA, TX_DATA};
          cnt_n   = '0;
          state_n = INHIBIT;
        end
      end

      INHIBIT: begin
        PS2_CLK_OE = 1'b1;
        if (cnt == INH_LAST) begin
          cnt_n   = '0;
          state_n = REQUEST;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      REQUEST: begin
        PS2_CLK_OE  = 1'b1;
        PS2_DATA_OE = 1'b1;
        if (cnt == REQ_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          dat_q_n = 1'b1;
          state_n = SEND;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      SEND: begin
        PS2_DATA_OE = dat_q;
        if (fall) begin
          dat_q_n = ~frame[idx];
          idx_n   = idx + 4'd1;
          if (idx == 4'd9) begin
            state_n = ACK;
          end
        end
      end

      ACK: begin
        if (fall) begin
          if (!dat_sync) begin
            state_n = WAIT_IDLE;
          end else begin
            ERR     = 1'b1;
            state_n = IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          DONE    = 1'b1;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

`ifdef PS2_TX_WATCHDOG_EN
    // Expiry never coincides with a falling edge, so it cannot collide
    // with the ACK-phase ERR; a completing WAIT_IDLE keeps its DONE.
    if (wd_expired && !DONE) begin
      ERR         = 1'b1;
      PS2_DATA_OE = 1'b0;
      state_n     = IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx with a PS/2
// device model on open-collector lines. Build with PS2_TX_WATCHDOG_EN
// defined to exercise the watchdog instead of the indefinite wait.

module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned REQ = 4;
  localparam int unsigned TMO = 1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [7:0] TX_DATA = '0;
  logic       PS2_CLK_IN;
  logic       PS2_DATA_IN;
  logic       PS2_CLK_OE;
  logic       PS2_DATA_OE;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  assign PS2_CLK_IN  = dev_clk & ~PS2_CLK_OE;
  assign PS2_DATA_IN = dev_data & ~PS2_DATA_OE;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .TX_DATA    (TX_DATA),
    .PS2_CLK_IN (PS2_CLK_IN),
    .PS2_DATA_IN(PS2_DATA_IN),
    .PS2_CLK_OE (PS2_CLK_OE),
    .PS2_DATA_OE(PS2_DATA_OE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned done_seen = 0;
  int unsigned err_seen = 0;
  int unsigned both_seen = 0;
  int unsigned stray_seen = 0;

  always begin
    @(posedge CLK);
    #1;
    if (DONE === 1'b1) done_seen++;
    if (ERR === 1'b1) err_seen++;
    if (DONE === 1'b1 && ERR === 1'b1) both_seen++;
    if ((DONE === 1'b1 || ERR === 1'b1) && BUSY !== 1'b1) stray_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required to finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = d[i];
    f[8] = (($countones(d) % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic edges(input int unsigned n, input int unsigned half, output logic [9:0] bits);
    bits = '0;
    for (int unsigned k = 0; k < n; k++) begin
      dev_clk = 1'b0;
      repeat (half) tick();
      dev_clk = 1'b1;
      bits[k] = PS2_DATA_IN;
      repeat (half) tick();
    end
  endtask

  task automatic open_xfer(input string tag, input logic [7:0] data, input bit extra_start,
                           input int unsigned half);
    int unsigned inh;
    int unsigned rq;
    TX_DATA = data;
    START   = 1'b1;
    check({tag, ".busy_idle"}, BUSY, 1'b0);
    tick();
    START   = 1'b0;
    TX_DATA = ~data;
    check({tag, ".busy_accept"}, BUSY, 1'b1);
    inh = 0;
    while (PS2_CLK_OE === 1'b1 && PS2_DATA_OE === 1'b0 && inh < 4 * INH) begin
      inh++;
      START = extra_start && (inh == 3);
      tick();
    end
    START = 1'b0;
    check({tag, ".inhibit_len"}, inh, INH);
    rq = 0;
    while (PS2_CLK_OE === 1'b1 && PS2_DATA_OE === 1'b1 && rq < 4 * REQ) begin
      rq++;
      tick();
    end
    check({tag, ".request_len"}, rq, REQ);
    check({tag, ".send_oe"}, {PS2_CLK_OE, PS2_DATA_OE}, 2'b01);
    check({tag, ".start_bit"}, PS2_DATA_IN, 1'b0);
    repeat (half) tick();
  endtask

  task automatic xfer(input string tag, input logic [7:0] data, input bit ack,
                      input int unsigned half, input bit extra_start, input bit start_on_done,
                      input logic [9:0] exp_bits, input bit exp_done);
    logic [9:0]  bits;
    int unsigned d0;
    int unsigned e0;
    int unsigned g;
    logic        pd;
    logic        pe;
    d0 = done_seen;
    e0 = err_seen;
    open_xfer(tag, data, extra_start, half);
    edges(10, half, bits);
    check({tag, ".line_bits"}, bits, exp_bits);
    dev_data = !ack;
    repeat (2) tick();
    dev_clk = 1'b0;
    g  = 0;
    pd = 1'b0;
    pe = 1'b0;
    while (BUSY === 1'b1 && g < 400) begin
      if (g == half) begin
        dev_clk  = 1'b1;
        dev_data = 1'b1;
      end
      pd    = DONE;
      pe    = ERR;
      START = start_on_done && (DONE === 1'b1 || ERR === 1'b1);
      TX_DATA = 8'($urandom);
      g++;
      tick();
    end
    START    = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    check({tag, ".end_in_time"}, (g < 400), 1'b1);
    check({tag, ".last_busy_pulse"}, {pd, pe}, exp_done ? 2'b10 : 2'b01);
    tick();
    check({tag, ".busy_after"}, BUSY, 1'b0);
    check({tag, ".oe_released"}, {PS2_CLK_OE, PS2_DATA_OE}, 2'b00);
    check({tag, ".done_count"}, done_seen - d0, exp_done ? 1 : 0);
    check({tag, ".err_count"}, err_seen - e0, exp_done ? 0 : 1);
    repeat (3) tick();
  endtask

  task automatic abort_test();
    logic [9:0]  junk;
    int unsigned d0;
    int unsigned e0;
    d0 = done_seen;
    e0 = err_seen;
    open_xfer("abort", 8'hAA, 1'b0, 6);
    edges(4, 6, junk);
    dev_clk = 1'b0;
    repeat (3) tick();
    check("abort.data_driven", PS2_DATA_OE, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("abort.async_outs", {PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERR}, 5'b0);
    tick();
    dev_clk = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    repeat (3) tick();
    check("abort.no_done", done_seen - d0, 0);
    check("abort.no_err", err_seen - e0, 0);
  endtask

  task automatic stall_test();
    logic [9:0]  junk;
    int unsigned d0;
    int unsigned e0;
    d0 = done_seen;
    e0 = err_seen;
    open_xfer("stall", 8'h5A, 1'b0, 6);
    edges(3, 6, junk);
    dev_clk = 1'b0;
`ifdef PS2_TX_WATCHDOG_EN
    begin
      int unsigned k;
      k = 0;
      while (ERR !== 1'b1 && k < 3 * TMO) begin
        tick();
        k++;
      end
      // two synchronizer stages sit between the line edge and the detected fall
      check("stall.wd_latency", k, TMO + 2);
      check("stall.wd_oe", {PS2_CLK_OE, PS2_DATA_OE}, 2'b00);
      tick();
      check("stall.wd_busy", BUSY, 1'b0);
      dev_clk = 1'b1;
      repeat (4) tick();
      check("stall.wd_err_count", err_seen - e0, 1);
      check("stall.wd_done_count", done_seen - d0, 0);
    end
`else
    repeat (3 * TMO) tick();
    check("stall.still_busy", BUSY, 1'b1);
    check("stall.no_err", err_seen - e0, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    dev_clk = 1'b1;
    repeat (3) tick();
    check("stall.busy_cleared", BUSY, 1'b0);
`endif
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    int unsigned half;
    bit          extra_start;
    bit          start_on_done;
    logic [9:0]  exp_bits;
    bit          exp_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{8'hED, 1'b1, 6, 1'b0, 1'b0, 10'h3ED, 1'b1};
    tbl[1] = '{8'hF4, 1'b1, 5, 1'b0, 1'b0, 10'h2F4, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 8, 1'b0, 1'b0, 10'h300, 1'b1};
    tbl[3] = '{8'h01, 1'b0, 6, 1'b0, 1'b0, 10'h201, 1'b0};
    tbl[4] = '{8'hA5, 1'b1, 7, 1'b1, 1'b0, 10'h3A5, 1'b1};
    tbl[5] = '{8'h3C, 1'b1, 4, 1'b0, 1'b1, 10'h33C, 1'b1};
    tbl[6] = '{8'h7E, 1'b0, 5, 1'b0, 1'b1, 10'h37E, 1'b0};

    repeat (3) tick();
    check("reset.outs", {PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERR}, 5'b0);
    RST = 1'b0;
    repeat (2) tick();
    check("reset.idle_outs", {PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERR}, 5'b0);

    for (int i = 0; i < 7; i++) begin
      xfer($sformatf("vec%0d", i), tbl[i].data, tbl[i].ack, tbl[i].half,
           tbl[i].extra_start, tbl[i].start_on_done, tbl[i].exp_bits, tbl[i].exp_done);
    end

    abort_test();
    xfer("after_abort", 8'hFF, 1'b1, 6, 1'b0, 1'b0, 10'h3FF, 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [7:0]  d;
      bit          a;
      int unsigned h;
      d = 8'($urandom);
      a = ($urandom_range(0, 3) != 0);
      h = $urandom_range(4, 12);
      xfer($sformatf("rnd%0d", i), d, a, h, bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), ref_frame(d), a);
    end

    stall_test();

    check("global.done_err_overlap", both_seen, 0);
    check("global.pulse_outside_xfer", stray_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
